// File: rtl/serializer_if.sv
// rtl/serializer_if.sv - word-in / bit-out handshake bundle for the serializer
// master = word producer, slave = serializer.
interface serializer_if #(
  parameter int DATA_WIDTH = 8
);
  logic [DATA_WIDTH-1:0] data_in;
  logic                  data_valid;
  logic                  ready_out;
  logic                  data_out;
  logic                  write_out;
  logic                  busy_out;
  logic                  byte_done;

  modport master (
    output data_in, data_valid,
    input  ready_out, data_out, write_out, busy_out, byte_done
  );

  modport slave (
    input  data_in, data_valid,
    output ready_out, data_out, write_out, busy_out, byte_done
  );
endinterface

// File: rtl/serializer.sv
// rtl/serializer.sv - parallel word to serial bit stream with optional inter-word gap
// IDLE -> SHIFT (DATA_WIDTH bits) -> [GAP] -> IDLE; back-to-back reload when GAP_CYCLES=0.
module serializer #(
  parameter int DATA_WIDTH = 8,
  parameter int MSB_FIRST  = 1,
  parameter int GAP_CYCLES = 0
) (
  input  logic        i_clk,
  input  logic        i_rst,
  serializer_if.slave io_if
);
  localparam int CW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_GAP   = 2'd2;

  logic [1:0]            r_state;
  logic [DATA_WIDTH-1:0] r_shift;
  logic [CW-1:0]         r_cnt;
  logic [3:0]            r_gap;

  logic w_last;
  logic w_ready;
  logic w_accept;
  logic w_bit;

  assign w_last   = (r_state == S_SHIFT) && (r_cnt == CW'(DATA_WIDTH - 1));
  // Ready depends on state only so a producer can never loop valid back into it.
  assign w_ready  = (r_state == S_IDLE) || ((GAP_CYCLES == 0) && w_last);
  assign w_accept = io_if.data_valid && w_ready;
  assign w_bit    = (MSB_FIRST != 0) ? r_shift[DATA_WIDTH-1] : r_shift[0];

  assign io_if.ready_out = w_ready;
  assign io_if.write_out = (r_state == S_SHIFT);
  assign io_if.data_out  = (r_state == S_SHIFT) && w_bit;
  assign io_if.busy_out  = (r_state != S_IDLE);
  assign io_if.byte_done = w_last;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= S_IDLE;
      r_shift <= '0;
      r_cnt   <= '0;
      r_gap   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_shift <= io_if.data_in;
            r_cnt   <= '0;
            r_state <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          if (w_last) begin
            if (GAP_CYCLES > 0) begin
              r_state <= S_GAP;
              r_gap   <= '0;
              r_shift <= '0;
              r_cnt   <= '0;
            end else if (w_accept) begin
              r_shift <= io_if.data_in;
              r_cnt   <= '0;
            end else begin
              r_state <= S_IDLE;
              r_shift <= '0;
              r_cnt   <= '0;
            end
          end else begin
            if (MSB_FIRST != 0) begin
              r_shift <= {r_shift[DATA_WIDTH-2:0], 1'b0};
            end else begin
              r_shift <= {1'b0, r_shift[DATA_WIDTH-1:1]};
            end
            r_cnt <= r_cnt + CW'(1);
          end
        end
        S_GAP: begin
          if (r_gap == 4'(GAP_CYCLES - 1)) begin
            r_state <= S_IDLE;
            r_gap   <= '0;
          end else begin
            r_gap <= r_gap + 4'd1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_serializer.sv
// tb/tb_serializer.sv - three serializer configurations against a cycle-timeline reference model
// d0: MSB first no gap, d1: MSB first gap 2, d2: LSB first no gap.
module tb_serializer;
  localparam int DW  = 8;
  localparam int TLN = 2048;

  logic       clk;
  logic       rst;
  logic [7:0] din [3];
  logic       vld [3];
  logic [4:0] obs [3];

  serializer_if #(.DATA_WIDTH(DW)) if0 ();
  serializer_if #(.DATA_WIDTH(DW)) if1 ();
  serializer_if #(.DATA_WIDTH(DW)) if2 ();

  assign if0.data_in = din[0];
  assign if0.data_valid = vld[0];
  assign if1.data_in = din[1];
  assign if1.data_valid = vld[1];
  assign if2.data_in = din[2];
  assign if2.data_valid = vld[2];
  assign obs[0] = {if0.write_out, if0.data_out, if0.busy_out, if0.byte_done, if0.ready_out};
  assign obs[1] = {if1.write_out, if1.data_out, if1.busy_out, if1.byte_done, if1.ready_out};
  assign obs[2] = {if2.write_out, if2.data_out, if2.busy_out, if2.byte_done, if2.ready_out};

  serializer #(.DATA_WIDTH(DW), .MSB_FIRST(1), .GAP_CYCLES(0)) u_d0 (.i_clk(clk), .i_rst(rst), .io_if(if0));
  serializer #(.DATA_WIDTH(DW), .MSB_FIRST(1), .GAP_CYCLES(2)) u_d1 (.i_clk(clk), .i_rst(rst), .io_if(if1));
  serializer #(.DATA_WIDTH(DW), .MSB_FIRST(0), .GAP_CYCLES(0)) u_d2 (.i_clk(clk), .i_rst(rst), .io_if(if2));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  // Expected per-cycle outputs {write, bit, busy, done}; tl_end is the first unscheduled cycle.
  logic [3:0] tl [3][0:TLN-1];
  int         tl_end [3];

  logic [31:0] str [3];
  int          wcnt [3];
  int          first_wr [3];
  int          last_wr [3];
  int          last_done [3];
  int          prev_done [3];
  int          nbg [3];
  int          wr_cyc1 [$];

  function automatic int gap_of(input int d);
    return (d == 1) ? 2 : 0;
  endfunction

  function automatic bit msb_of(input int d);
    return (d != 2);
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic clear_cap();
    for (int d = 0; d < 3; d++) begin
      str[d] = '0;
      wcnt[d] = 0;
      first_wr[d] = -1;
      last_wr[d] = -1;
      last_done[d] = -1;
      prev_done[d] = -1;
      nbg[d] = 0;
    end
    wr_cyc1.delete();
  endtask

  task automatic drive_all(input logic v, input logic [7:0] w);
    for (int d = 0; d < 3; d++) begin
      vld[d] = v;
      din[d] = w;
    end
  endtask

  task automatic step();
    logic [3:0] e;
    logic       er;
    int         idx;
    @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      if (rst) tl_end[d] = cyc;
      e  = (cyc < tl_end[d]) ? tl[d][cyc] : 4'b0000;
      er = (cyc >= tl_end[d]) || ((gap_of(d) == 0) && (cyc == tl_end[d] - 1));
      check($sformatf("d%0d_write c%0d", d, cyc), 32'(obs[d][4]), 32'(e[3]));
      check($sformatf("d%0d_data c%0d", d, cyc), 32'(obs[d][3]), 32'(e[2]));
      check($sformatf("d%0d_busy c%0d", d, cyc), 32'(obs[d][2]), 32'(e[1]));
      check($sformatf("d%0d_done c%0d", d, cyc), 32'(obs[d][1]), 32'(e[0]));
      check($sformatf("d%0d_ready c%0d", d, cyc), 32'(obs[d][0]), 32'(er));
      if (obs[d][4]) begin
        str[d] = {str[d][30:0], obs[d][3]};
        wcnt[d]++;
        if (first_wr[d] < 0) first_wr[d] = cyc;
        last_wr[d] = cyc;
        if (d == 1) wr_cyc1.push_back(cyc);
      end
      if (obs[d][2] && !obs[d][4]) nbg[d]++;
      if (obs[d][1]) begin
        prev_done[d] = last_done[d];
        last_done[d] = cyc;
      end
      if (!rst && er && vld[d]) begin
        for (int k = 0; k < DW; k++) begin
          idx = cyc + 1 + k;
          if (idx < TLN)
            tl[d][idx] = {1'b1, (msb_of(d) ? din[d][DW-1-k] : din[d][k]), 1'b1, (k == DW - 1)};
        end
        for (int g = 0; g < gap_of(d); g++) begin
          idx = cyc + 1 + DW + g;
          if (idx < TLN) tl[d][idx] = 4'b0010;
        end
        tl_end[d] = cyc + 1 + DW + gap_of(d);
      end
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  initial begin
    rst = 1'b1;
    for (int d = 0; d < 3; d++) tl_end[d] = 0;
    drive_all(1'b0, 8'h00);
    clear_cap();

    // Reset held, then idle.
    repeat (5) step();
    rst = 1'b0;
    repeat (8) step();

    // Single word 0xA5.
    clear_cap();
    drive_all(1'b1, 8'hA5);
    step();
    drive_all(1'b0, 8'h00);
    repeat (12) step();
    check("a5_bits", str[0], 32'h0000_00A5);
    check("a5_count", 32'(wcnt[0]), 32'd8);

    // Valid held: 0xA5 then 0x3C streamed with no hole on d0.
    clear_cap();
    drive_all(1'b1, 8'hA5);
    step();
    drive_all(1'b1, 8'h3C);
    repeat (8) step();
    drive_all(1'b0, 8'h00);
    repeat (14) step();
    check("stream_bits", str[0], 32'h0000_A53C);
    check("stream_count", 32'(wcnt[0]), 32'd16);
    check("stream_span", 32'(last_wr[0] - first_wr[0]), 32'd15);
    check("stream_done_spacing", 32'(last_done[0] - prev_done[0]), 32'd8);

    // Gap of 2 between two words on d1.
    clear_cap();
    drive_all(1'b1, 8'h5A);
    step();
    drive_all(1'b1, 8'hC3);
    repeat (11) step();
    drive_all(1'b0, 8'h00);
    repeat (16) step();
    check("gap_bits", str[1], 32'h0000_5AC3);
    check("gap_count", 32'(wcnt[1]), 32'd16);
    check("gap_span", (wr_cyc1.size() >= 9) ? 32'(wr_cyc1[8] - wr_cyc1[7]) : 32'hFFFF_FFFF, 32'd4);
    check("gap_busy_idle", 32'(nbg[1]), 32'd4);

    // LSB first 0x01.
    clear_cap();
    drive_all(1'b1, 8'h01);
    step();
    drive_all(1'b0, 8'h00);
    repeat (12) step();
    check("lsb_bits", str[2], 32'h0000_0080);
    check("msb_bits_01", str[0], 32'h0000_0001);

    // Reset during bit 4 of 0xFF, then 0x80.
    clear_cap();
    drive_all(1'b1, 8'hFF);
    step();
    drive_all(1'b0, 8'h00);
    repeat (3) step();
    check("abort_pre_write", 32'(obs[0][4]), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    check("abort_write", 32'(obs[0][4]), 32'd0);
    check("abort_busy", 32'(obs[0][2]), 32'd0);
    check("abort_ready", 32'(obs[0][0]), 32'd1);
    check("abort_data", 32'(obs[0][3]), 32'd0);
    step();
    rst = 1'b0;
    check("abort_bits_seen", 32'(wcnt[0]), 32'd3);
    clear_cap();
    drive_all(1'b1, 8'h80);
    step();
    drive_all(1'b0, 8'h00);
    repeat (12) step();
    check("after_abort_bits", str[0], 32'h0000_0080);
    check("after_abort_count", 32'(wcnt[0]), 32'd8);

    // Randomized traffic with occasional asynchronous resets.
    repeat (700) begin
      for (int d = 0; d < 3; d++) begin
        vld[d] = ($urandom_range(0, 9) < 6);
        din[d] = 8'($urandom);
      end
      rst = ($urandom_range(0, 199) == 0);
      step();
    end
    rst = 1'b0;
    drive_all(1'b0, 8'h00);
    repeat (14) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
